ras_ctrl: RTL and testbench

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/ras_ctrl_if.sv | 45 ++++
 rtl/ras_ctrl.sv | 151 +++++++++++++++
 tb/tb_ras_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_ctrl_if.sv
// Pipeline/call-stack side signals of the return-address-stack controller.
// The slave modport is the controller; the master modport is the pipeline/stack side driving it.
interface ras_ctrl_if #(
  parameter int unsigned DPT = 8,
  parameter int unsigned DW  = 32
);
  localparam int unsigned PTRW = $clog2(DPT);

  logic            i_adv;
  logic            i_fu_vld;
  logic            i_fu_is_call;
  logic            i_fu_is_ret;
  logic [DW-1:0]   i_fu_pc;
  logic            i_flush;
  logic [PTRW-1:0] i_stack_ptr;
  logic            i_stack_full;
  logic            i_stack_empty;
  logic [DW-1:0]   i_pop_data;

  logic            o_push_en;
  logic [DW-1:0]   o_push_data;
  logic            o_pop_en;
  logic            o_rbk_en;
  logic [PTRW-1:0] o_rbk_ptr;
  logic            o_rbk_full;
  logic            o_rbk_incr_ptr;
  logic [1:0]      o_spec_state;
  logic            o_pred_vld;
  logic [DW-1:0]   o_pred_addr;
  logic            o_stall;

  modport master (
    output i_adv, i_fu_vld, i_fu_is_call, i_fu_is_ret, i_fu_pc, i_flush,
           i_stack_ptr, i_stack_full, i_stack_empty, i_pop_data,
    input  o_push_en, o_push_data, o_pop_en, o_rbk_en, o_rbk_ptr, o_rbk_full,
           o_rbk_incr_ptr, o_spec_state, o_pred_vld, o_pred_addr, o_stall
  );

  modport slave (
    input  i_adv, i_fu_vld, i_fu_is_call, i_fu_is_ret, i_fu_pc, i_flush,
           i_stack_ptr, i_stack_full, i_stack_empty, i_pop_data,
    output o_push_en, o_push_data, o_pop_en, o_rbk_en, o_rbk_ptr, o_rbk_full,
           o_rbk_incr_ptr, o_spec_state, o_pred_vld, o_pred_addr, o_stall
  );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: pushes/pops the call stack at decode and
// tracks two speculative slots so a branch flush can roll the stack back.
module ras_ctrl #(
  parameter int unsigned DPT = 8,
  parameter int unsigned DW  = 32
) (
  input logic      clk,
  input logic      aresetn,
  ras_ctrl_if.slave bus
);
  localparam int unsigned PTRW = $clog2(DPT);

  typedef enum logic [1:0] {
    K_OTHER = 2'd0,
    K_CALL  = 2'd1,
    K_RET   = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RBK1 = 2'd1,
    RBK2 = 2'd2
  } state_e;

  typedef struct packed {
    logic            vld;
    kind_e           kind;
    logic [PTRW-1:0] ptr_snap;
    logic            full_snap;
  } slot_t;

  state_e          state;
  slot_t           slot_a;
  slot_t           slot_b;
  logic [PTRW-1:0] rbk_ptr;
  logic            rbk_full;
  logic [1:0]      rbk_spec;
  logic            rbk_en;
  logic            stall;

  kind_e           fu_kind;
  kind_e           kind_a;
  kind_e           kind_b;
  logic            accept;
  logic [1:0]      spec_now;
  logic [PTRW-1:0] sel_ptr;
  logic            sel_full;

  function automatic logic [1:0] spec_of(input kind_e kb, input kind_e ka);
    logic [1:0] s;
    s = 2'b00;
    if (ka == K_CALL) begin
      if (kb == K_CALL)     s = 2'b10;
      else if (kb == K_RET) s = 2'b11;
      else                  s = 2'b01;
    end else if (kb == K_CALL) begin
      s = 2'b01;
    end
    return s;
  endfunction

  always_comb begin
    fu_kind = K_OTHER;
    if (bus.i_fu_is_call)     fu_kind = K_CALL;
    else if (bus.i_fu_is_ret) fu_kind = K_RET;
  end

  // aresetn gates accept so the combinational push/pop/predict outputs are
  // also forced low while reset is held.
  assign accept = aresetn && bus.i_fu_vld && bus.i_adv && (state == IDLE) && !bus.i_flush;

  assign kind_a   = slot_a.vld ? slot_a.kind : K_OTHER;
  assign kind_b   = slot_b.vld ? slot_b.kind : K_OTHER;
  assign spec_now = spec_of(kind_b, kind_a);

  // The oldest live speculative op holds the stack state to restore.
  always_comb begin
    sel_ptr  = bus.i_stack_ptr;
    sel_full = bus.i_stack_full;
    if (slot_b.vld) begin
      sel_ptr  = slot_b.ptr_snap;
      sel_full = slot_b.full_snap;
    end else if (slot_a.vld) begin
      sel_ptr  = slot_a.ptr_snap;
      sel_full = slot_a.full_snap;
    end
  end

  assign bus.o_push_en      = accept && (fu_kind == K_CALL);
  assign bus.o_push_data    = bus.o_push_en ? (bus.i_fu_pc + DW'(4)) : '0;
  assign bus.o_pop_en       = accept && (fu_kind == K_RET);
  assign bus.o_pred_vld     = bus.o_pop_en && !bus.i_stack_empty;
  assign bus.o_pred_addr    = bus.o_pred_vld ? bus.i_pop_data : '0;
  assign bus.o_rbk_en       = rbk_en;
  assign bus.o_rbk_ptr      = rbk_ptr;
  assign bus.o_rbk_full     = rbk_full;
  assign bus.o_rbk_incr_ptr = 1'b0;
  assign bus.o_stall        = stall;
  assign bus.o_spec_state   = (state == IDLE) ? spec_now : rbk_spec;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      slot_a   <= '0;
      slot_b   <= '0;
      rbk_ptr  <= '0;
      rbk_full <= 1'b0;
      rbk_spec <= '0;
      rbk_en   <= 1'b0;
      stall    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_flush) begin
            rbk_ptr    <= sel_ptr;
            rbk_full   <= sel_full;
            rbk_spec   <= spec_now;
            slot_a.vld <= 1'b0;
            slot_b.vld <= 1'b0;
            rbk_en     <= 1'b1;
            stall      <= 1'b1;
            state      <= RBK1;
          end else if (bus.i_adv) begin
            slot_b <= slot_a;
            if (accept) begin
              slot_a <= '{vld:       1'b1,
                          kind:      fu_kind,
                          ptr_snap:  bus.i_stack_ptr,
                          full_snap: bus.i_stack_full};
            end else begin
              slot_a.vld <= 1'b0;
            end
          end
        end
        RBK1: begin
          rbk_en <= 1'b0;
          state  <= RBK2;
        end
        RBK2: begin
          stall <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rbk_en <= 1'b0;
          stall  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed vectors, a two-entry speculation-window model
// checked every cycle, plus literal expectations for the worked examples.
module tb_ras_ctrl;
  localparam int DPT  = 8;
  localparam int DW   = 32;
  localparam int PTRW = 3;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  ras_ctrl_if #(.DPT(DPT), .DW(DW)) bus();
  ras_ctrl #(.DPT(DPT), .DW(DW)) dut (.clk(clk), .aresetn(aresetn), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- model: kinds 0=other 1=call 2=ret; rb_left counts rollback cycles left
  typedef struct {
    bit vld;
    int kind;
    int ptr;
    bit full;
  } ent_t;
  localparam ent_t NONE = '{vld: 1'b0, kind: 0, ptr: 0, full: 1'b0};

  ent_t m_old = NONE;
  ent_t m_new = NONE;
  int   rb_left = 0;
  int   rb_ptr = 0;
  int   rb_spec = 0;
  bit   rb_full = 1'b0;

  function automatic int kind_of(input bit call, input bit ret);
    return call ? 1 : (ret ? 2 : 0);
  endfunction

  function automatic int eff(input ent_t e);
    return e.vld ? e.kind : 0;
  endfunction

  function automatic int spec_of(input ent_t b, input ent_t a);
    if (eff(a) == 1) return (eff(b) == 1) ? 2 : ((eff(b) == 2) ? 3 : 1);
    return (eff(b) == 1) ? 1 : 0;
  endfunction

  function automatic bit m_acc();
    return aresetn && rb_left == 0 && bus.i_fu_vld && bus.i_adv && !bus.i_flush;
  endfunction

  function automatic int m_kind();
    return kind_of(bus.i_fu_is_call, bus.i_fu_is_ret);
  endfunction

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_old   <= NONE;
      m_new   <= NONE;
      rb_left <= 0;
      rb_ptr  <= 0;
      rb_spec <= 0;
      rb_full <= 1'b0;
    end else if (rb_left > 0) begin
      rb_left <= rb_left - 1;
    end else if (bus.i_flush) begin
      rb_left <= 2;
      rb_spec <= spec_of(m_old, m_new);
      rb_ptr  <= m_old.vld ? m_old.ptr : (m_new.vld ? m_new.ptr : int'(bus.i_stack_ptr));
      rb_full <= m_old.vld ? m_old.full : (m_new.vld ? m_new.full : bus.i_stack_full);
      m_old   <= NONE;
      m_new   <= NONE;
    end else if (bus.i_adv) begin
      m_old <= m_new;
      m_new <= bus.i_fu_vld ? '{vld: 1'b1, kind: m_kind(), ptr: int'(bus.i_stack_ptr),
                                full: bus.i_stack_full} : NONE;
    end
  end

  always @(negedge clk) begin
    chk("push_en", bus.o_push_en, m_acc() && m_kind() == 1);
    chk("pop_en", bus.o_pop_en, m_acc() && m_kind() == 2);
    chk("pred_vld", bus.o_pred_vld, m_acc() && m_kind() == 2 && !bus.i_stack_empty);
    if (m_acc() && m_kind() == 1) chk("push_data", bus.o_push_data, bus.i_fu_pc + 32'd4);
    if (m_acc() && m_kind() == 2 && !bus.i_stack_empty)
      chk("pred_addr", bus.o_pred_addr, bus.i_pop_data);
    chk("rbk_en", bus.o_rbk_en, aresetn && rb_left == 2);
    if (aresetn && rb_left == 2) begin
      chk("rbk_ptr", bus.o_rbk_ptr, rb_ptr);
      chk("rbk_full", bus.o_rbk_full, rb_full);
    end
    chk("rbk_incr_ptr", bus.o_rbk_incr_ptr, 0);
    chk("spec_state", bus.o_spec_state,
        !aresetn ? 0 : (rb_left > 0 ? rb_spec : spec_of(m_old, m_new)));
    chk("stall", bus.o_stall, aresetn && rb_left > 0);
    if (!aresetn) begin
      chk("rst_push_data", bus.o_push_data, 0);
      chk("rst_pred_addr", bus.o_pred_addr, 0);
      chk("rst_rbk_ptr", bus.o_rbk_ptr, 0);
      chk("rst_rbk_full", bus.o_rbk_full, 0);
    end
  end

  // ---- stimulus: drive one cycle, stop at the negedge for literal checks
  task automatic drive(input bit vld, input bit call, input bit ret, input logic [31:0] pc,
                       input bit flush, input bit adv, input int ptr, input bit full,
                       input bit empty, input logic [31:0] pop);
    bus.i_fu_vld      = vld;
    bus.i_fu_is_call  = call;
    bus.i_fu_is_ret   = ret;
    bus.i_fu_pc       = pc;
    bus.i_flush       = flush;
    bus.i_adv         = adv;
    bus.i_stack_ptr   = PTRW'(ptr);
    bus.i_stack_full  = full;
    bus.i_stack_empty = empty;
    bus.i_pop_data    = pop;
  endtask

  task automatic go(input bit vld, input bit call, input bit ret, input logic [31:0] pc,
                    input bit flush, input bit adv, input int ptr, input bit full,
                    input bit empty, input logic [31:0] pop);
    drive(vld, call, ret, pc, flush, adv, ptr, full, empty, pop);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    go(0, 0, 0, 32'h0, 0, 0, 0, 0, 1, 32'h0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 1, 0, 32'h40, 0, 1, 2, 0, 1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_push_en_gated", bus.o_push_en, 0);
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_spec", bus.o_spec_state, 0);
    aresetn = 1'b1;
    idle(); next();

    // CALL at ptr=3, pc=0x100
    go(1, 1, 0, 32'h100, 0, 1, 3, 0, 1, 32'h0);
    chk("lit_push_en", bus.o_push_en, 1);
    chk("lit_push_data_104", bus.o_push_data, 32'h104);
    next();
    idle();
    chk("lit_spec_A_call", bus.o_spec_state, 2'b01);
    next();
    go(0, 0, 0, 32'h0, 1, 0, 7, 0, 1, 32'h0);
    next();
    idle();
    chk("lit_rbk_ptr_A", bus.o_rbk_ptr, 3);
    chk("lit_rbk_en_A", bus.o_rbk_en, 1);
    next();
    idle(); next();
    idle();
    chk("lit_stall_done", bus.o_stall, 0);
    next();

    // CALL(ptr2), CALL(ptr3), flush colliding with a valid fetch
    go(1, 1, 0, 32'h200, 0, 1, 2, 0, 1, 32'h0); next();
    go(1, 1, 0, 32'h300, 0, 1, 3, 0, 1, 32'h0); next();
    go(1, 1, 0, 32'h400, 1, 1, 4, 0, 1, 32'h0);
    chk("lit_flush_wins", bus.o_push_en, 0);
    next();
    idle();
    chk("lit_rbk_en_cc", bus.o_rbk_en, 1);
    chk("lit_rbk_ptr_cc", bus.o_rbk_ptr, 2);
    chk("lit_spec_cc", bus.o_spec_state, 2'b10);
    chk("lit_stall_cc1", bus.o_stall, 1);
    next();
    go(1, 1, 0, 32'h500, 1, 1, 5, 0, 1, 32'h0);
    chk("lit_stall_cc2", bus.o_stall, 1);
    chk("lit_spec_cc2", bus.o_spec_state, 2'b10);
    chk("lit_no_push_rbk2", bus.o_push_en, 0);
    next();
    idle(); next();

    // RET(ptr5, pop 0x2000) then CALL, flush
    go(1, 0, 1, 32'h600, 0, 1, 5, 0, 0, 32'h2000);
    chk("lit_pred_vld", bus.o_pred_vld, 1);
    chk("lit_pred_addr", bus.o_pred_addr, 32'h2000);
    chk("lit_pop_en", bus.o_pop_en, 1);
    next();
    go(1, 1, 0, 32'h500, 0, 1, 4, 0, 0, 32'h2000); next();
    go(0, 0, 0, 32'h0, 1, 0, 5, 0, 0, 32'h0); next();
    idle();
    chk("lit_rbk_ptr_rc", bus.o_rbk_ptr, 5);
    chk("lit_spec_rc", bus.o_spec_state, 2'b11);
    next();
    idle(); next();
    idle(); next();

    // two OTHERs then flush; flush during RBK2 ignored
    go(1, 0, 0, 32'h700, 0, 1, 1, 0, 1, 32'h0); next();
    go(1, 0, 0, 32'h704, 0, 1, 2, 0, 1, 32'h0); next();
    go(0, 0, 0, 32'h0, 1, 0, 2, 0, 1, 32'h0); next();
    idle();
    chk("lit_rbk_en_oo", bus.o_rbk_en, 1);
    chk("lit_rbk_ptr_oo", bus.o_rbk_ptr, 1);
    chk("lit_spec_oo", bus.o_spec_state, 2'b00);
    next();
    go(0, 0, 0, 32'h0, 1, 0, 2, 0, 1, 32'h0); next();
    idle();
    chk("lit_idle_after_rbk", bus.o_stall, 0);
    next();
    idle();
    chk("lit_no_rerun", bus.o_rbk_en, 0);
    next();

    // RET on empty stack, call+ret decoded as CALL, full snapshot rollback
    go(1, 0, 1, 32'h0, 0, 1, 0, 0, 1, 32'h77);
    chk("lit_empty_pred", bus.o_pred_vld, 0);
    next();
    go(1, 1, 1, 32'h800, 0, 1, 0, 1, 0, 32'h0);
    chk("lit_callret_pop", bus.o_pop_en, 0);
    chk("lit_callret_data", bus.o_push_data, 32'h804);
    next();
    go(0, 0, 0, 32'h0, 0, 1, 1, 0, 1, 32'h0); next();
    go(0, 0, 0, 32'h0, 1, 0, 1, 0, 1, 32'h0);
    chk("lit_spec_c_o", bus.o_spec_state, 2'b01);
    next();
    idle();
    chk("lit_rbk_full", bus.o_rbk_full, 1);
    chk("lit_rbk_ptr_full", bus.o_rbk_ptr, 0);
    next();
    idle(); next();
    idle(); next();
    go(1, 1, 0, 32'h900, 0, 0, 1, 0, 1, 32'h0);
    chk("lit_no_adv", bus.o_push_en, 0);
    next();

    // PC wrap, then reset during RBK1
    go(1, 1, 0, 32'hFFFF_FFFC, 0, 1, 6, 0, 1, 32'h0);
    chk("lit_wrap", bus.o_push_data, 32'h0);
    next();
    go(0, 0, 0, 32'h0, 1, 0, 7, 0, 1, 32'h0); next();
    idle();
    chk("lit_rbk1_pre_rst", bus.o_rbk_en, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("lit_rst_rbk_en", bus.o_rbk_en, 0);
    chk("lit_rst_stall", bus.o_stall, 0);
    chk("lit_rst_spec", bus.o_spec_state, 0);
    next();
    aresetn = 1'b1;
    idle();
    chk("lit_post_rst_stall", bus.o_stall, 0);
    next();
    go(1, 1, 0, 32'h10, 0, 1, 1, 0, 1, 32'h0);
    chk("lit_post_rst_accept", bus.o_push_data, 32'h14);
    next();
    idle(); next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
